modular1: RTL and testbench



---
 rtl/modular1_pkg.sv | 14 +
 rtl/modular1_chan.sv | 92 +++++++++
 rtl/modular1.sv | 78 +++++++
 tb/tb_modular1.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/modular1_pkg.sv
// Shared types and constants for the three-channel start/abort counter block.
package modular1_pkg;

    localparam int unsigned CW              = 7;
    localparam int unsigned MAX_CNT_DEFAULT = 100;
    localparam int unsigned NUM_CHAN        = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chan_state_t;

endpackage : modular1_pkg

// File: rtl/modular1_chan.sv
// One start/abort counter channel: rising go edge starts a MAX_CNT-cycle run, kill aborts it.
module modular1_chan
    import modular1_pkg::*;
#(
    parameter int unsigned MAX_CNT = MAX_CNT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go_i,
    input  logic          kill_i,
    output logic [CW-1:0] count_o,
    output logic          done_o,
    output logic          kill_evt_c
);

    chan_state_t   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q,  done_d;
    logic          go_q;

    logic          start;
    logic [CW-1:0] count_inc;

    assign start     = go_i & ~go_q;
    assign count_inc = count_q + CW'(1);

    // Abort of an in-flight run, reported to the shared kill latch.
    assign kill_evt_c = kill_i & (state_q == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            go_q    <= go_i;
        end
    end

    // Priority inside a channel: kill over start over counting.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                if (start && !kill_i) begin
                    state_d = RUN;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                if (kill_i) begin
                    state_d = IDLE;
                    count_d = '0;
                    done_d  = 1'b0;
                end else begin
                    count_d = count_inc;
                    if (count_inc == CW'(MAX_CNT)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (kill_i) begin
                    state_d = IDLE;
                    count_d = '0;
                    done_d  = 1'b0;
                end else if (start) begin
                    state_d = RUN;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign count_o = count_q;
    assign done_o  = done_q;

endmodule : modular1_chan

// File: rtl/modular1.sv
// Three independent counter channels plus a sticky, software-cleared kill-status latch.
module modular1
    import modular1_pkg::*;
#(
    parameter int unsigned MAX_CNT = MAX_CNT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go_1,
    input  logic          go_2,
    input  logic          go_3,
    input  logic          kill_1,
    input  logic          kill_2,
    input  logic          kill_3,
    input  logic          kill_clr,
    output logic          kill_ltchd,
    output logic          done_1,
    output logic          done_2,
    output logic          done_3,
    output logic [CW-1:0] count_1,
    output logic [CW-1:0] count_2,
    output logic [CW-1:0] count_3
);

    logic [NUM_CHAN-1:0] kill_evt;
    logic                kill_ltchd_q, kill_ltchd_d;

    modular1_chan #(.MAX_CNT(MAX_CNT)) u_chan_1 (
        .clk        (clk),
        .reset      (reset),
        .go_i       (go_1),
        .kill_i     (kill_1),
        .count_o    (count_1),
        .done_o     (done_1),
        .kill_evt_c (kill_evt[0])
    );

    modular1_chan #(.MAX_CNT(MAX_CNT)) u_chan_2 (
        .clk        (clk),
        .reset      (reset),
        .go_i       (go_2),
        .kill_i     (kill_2),
        .count_o    (count_2),
        .done_o     (done_2),
        .kill_evt_c (kill_evt[1])
    );

    modular1_chan #(.MAX_CNT(MAX_CNT)) u_chan_3 (
        .clk        (clk),
        .reset      (reset),
        .go_i       (go_3),
        .kill_i     (kill_3),
        .count_o    (count_3),
        .done_o     (done_3),
        .kill_evt_c (kill_evt[2])
    );

    // A new abort wins over a same-cycle software clear.
    always_comb begin
        kill_ltchd_d = kill_ltchd_q;
        if (|kill_evt) begin
            kill_ltchd_d = 1'b1;
        end else if (kill_clr) begin
            kill_ltchd_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_ltchd_q <= 1'b0;
        end else begin
            kill_ltchd_q <= kill_ltchd_d;
        end
    end

    assign kill_ltchd = kill_ltchd_q;

endmodule : modular1

// File: tb/tb_modular1.sv
// Directed and randomized checks of modular1 against a behavioural channel model.
module tb_modular1;

    localparam int MAXC = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] go;
    logic [2:0] kill;
    logic       kill_clr;
    logic       kill_ltchd;
    logic       done_1, done_2, done_3;
    logic [6:0] count_1, count_2, count_3;

    int checks = 0;
    int errors = 0;

    // Behavioural model: whether a run is in flight, its count, done flag, last go sample.
    bit running [3];
    int m_cnt   [3];
    bit m_done  [3];
    bit m_pgo   [3];
    bit m_latch;

    always #5 clk = ~clk;

    modular1 #(.MAX_CNT(MAXC)) dut (
        .clk        (clk),
        .reset      (reset),
        .go_1       (go[0]),
        .go_2       (go[1]),
        .go_3       (go[2]),
        .kill_1     (kill[0]),
        .kill_2     (kill[1]),
        .kill_3     (kill[2]),
        .kill_clr   (kill_clr),
        .kill_ltchd (kill_ltchd),
        .done_1     (done_1),
        .done_2     (done_2),
        .done_3     (done_3),
        .count_1    (count_1),
        .count_2    (count_2),
        .count_3    (count_3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            running[c] = 1'b0;
            m_cnt[c]   = 0;
            m_done[c]  = 1'b0;
            m_pgo[c]   = 1'b0;
        end
        m_latch = 1'b0;
    endtask

    // One clock edge of the specified per-channel rules.
    task automatic model_step();
        bit any_abort;
        bit st;
        any_abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            st       = go[c] && !m_pgo[c];
            m_pgo[c] = go[c];
            if (running[c]) begin
                if (kill[c]) begin
                    any_abort  = 1'b1;
                    running[c] = 1'b0;
                    m_cnt[c]   = 0;
                    m_done[c]  = 1'b0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                    if (m_cnt[c] == MAXC) begin
                        running[c] = 1'b0;
                        m_done[c]  = 1'b1;
                    end
                end
            end else if (kill[c]) begin
                m_cnt[c]  = 0;
                m_done[c] = 1'b0;
            end else if (st) begin
                running[c] = 1'b1;
                m_cnt[c]   = 0;
                m_done[c]  = 1'b0;
            end
        end
        if (any_abort) m_latch = 1'b1;
        else if (kill_clr) m_latch = 1'b0;
    endtask

    task automatic check_all(input string phase);
        check({phase, ".count_1"}, 32'(count_1), 32'(m_cnt[0]));
        check({phase, ".count_2"}, 32'(count_2), 32'(m_cnt[1]));
        check({phase, ".count_3"}, 32'(count_3), 32'(m_cnt[2]));
        check({phase, ".done_1"}, 32'(done_1), 32'(m_done[0]));
        check({phase, ".done_2"}, 32'(done_2), 32'(m_done[1]));
        check({phase, ".done_3"}, 32'(done_3), 32'(m_done[2]));
        check({phase, ".kill_ltchd"}, 32'(kill_ltchd), 32'(m_latch));
    endtask

    // Advance one edge, update the model, then sample 1 time unit later.
    task automatic tick(input string phase);
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        check_all(phase);
    endtask

    task automatic ticks(input string phase, input int n);
        for (int i = 0; i < n; i++) tick(phase);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset_pulse(input string phase);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all({phase, ".async"});
        @(posedge clk);
        #1;
        check_all({phase, ".held"});
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        go       = '0;
        kill     = '0;
        kill_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Idle after reset release.
        ticks("idle", 5);
        check("idle.count_1_zero", 32'(count_1), 32'd0);
        check("idle.latch_zero", 32'(kill_ltchd), 32'd0);

        // Channel 1: go held high, runs to completion with no restart.
        go[0] = 1'b1;
        tick("ch1.start");
        ticks("ch1.run", MAXC);
        check("ch1.final_count", 32'(count_1), 32'(MAXC));
        check("ch1.final_done", 32'(done_1), 32'd1);
        ticks("ch1.hold", 5);
        check("ch1.held_count", 32'(count_1), 32'(MAXC));

        // Channel 2: kill after 4 counts sets the sticky latch.
        go[1] = 1'b1;
        tick("ch2.start");
        ticks("ch2.run", 4);
        check("ch2.count4", 32'(count_2), 32'd4);
        kill[1] = 1'b1;
        tick("ch2.kill");
        kill[1] = 1'b0;
        check("ch2.killed_count", 32'(count_2), 32'd0);
        check("ch2.latch_set", 32'(kill_ltchd), 32'd1);
        ticks("ch2.sticky", 3);
        check("ch2.latch_sticky", 32'(kill_ltchd), 32'd1);
        kill_clr = 1'b1;
        tick("ch2.clr");
        kill_clr = 1'b0;
        check("ch2.latch_cleared", 32'(kill_ltchd), 32'd0);

        // Channel 3: kill in IDLE and in DONE leaves the latch clear.
        kill[2] = 1'b1;
        tick("ch3.kill_idle");
        kill[2] = 1'b0;
        go[2] = 1'b1;
        tick("ch3.start");
        ticks("ch3.run", MAXC);
        check("ch3.done", 32'(done_3), 32'd1);
        kill[2] = 1'b1;
        tick("ch3.kill_done");
        kill[2] = 1'b0;
        check("ch3.cleared_count", 32'(count_3), 32'd0);
        check("ch3.cleared_done", 32'(done_3), 32'd0);
        check("ch3.latch_clear", 32'(kill_ltchd), 32'd0);

        // Channel 1 restart, then kill and kill_clr together: set wins.
        go[0] = 1'b0;
        tick("ch1.fall");
        go[0] = 1'b1;
        tick("ch1.restart");
        ticks("ch1.rerun", 3);
        check("ch1.rerun_count", 32'(count_1), 32'd3);
        kill[0]  = 1'b1;
        kill_clr = 1'b1;
        tick("ch1.kill_and_clr");
        kill[0]  = 1'b0;
        kill_clr = 1'b0;
        check("ch1.set_wins", 32'(kill_ltchd), 32'd1);

        // All three start together, then asynchronous reset at count 50.
        go = '0;
        tick("all.low");
        go = 3'b111;
        tick("all.start");
        ticks("all.run", 50);
        check("all.count50", 32'(count_2), 32'd50);
        go = '0;
        async_reset_pulse("all.reset");
        check("all.reset_count", 32'(count_1), 32'd0);
        ticks("all.after_reset", 3);
        check("all.stay_idle", 32'(count_3), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 29) == 0) go[c] = ~go[c];
                kill[c] = ($urandom_range(0, 299) == 0);
            end
            kill_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                async_reset_pulse("rand.reset");
            end else begin
                tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_modular1
